// File: rtl/xillybus_loopback_fifo.sv
// Loopback buffer between one Xillybus host-to-FPGA stream and one FPGA-to-host stream.
// Single bus_clk domain. Adds end-of-file signalling once the writer has closed and
// the buffer has drained, a sticky overflow flag and a fill-level output.
//
// state    | meaning
// IDLE     | no writer session seen since reset or flush
// ACTIVE   | writer has the device file open
// DRAINING | writer closed, words still waiting to be read
// EOF      | writer closed and every word has been delivered
module xillybus_loopback_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              bus_clk,
  input  logic              bus_rst_n,
  input  logic              user_w_wren,
  input  logic [DATA_W-1:0] user_w_data,
  input  logic              user_w_open,
  output logic              user_w_full,
  input  logic              user_r_rden,
  output logic [DATA_W-1:0] user_r_data,
  output logic              user_r_empty,
  output logic              user_r_eof,
  input  logic              user_r_open,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACTIVE   = 2'd1,
    S_DRAINING = 2'd2,
    S_EOF      = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp, rp;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              flush, wr_acc, rd_acc;

  // Both device files closed wipes the whole buffer and session.
  assign flush  = !user_w_open && !user_r_open;
  assign wr_acc = user_w_wren && !user_w_full;
  assign rd_acc = user_r_rden && !user_r_empty;

  // Count after this edge, used by the session FSM to detect drain.
  always_comb begin
    cnt_nxt = cnt;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge bus_clk) begin
    if (wr_acc && !flush) mem[wp] <= user_w_data;
  end

  // Pointers, count, overflow flag and registered read data.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      wp          <= '0;
      rp          <= '0;
      cnt         <= '0;
      overflow    <= 1'b0;
      user_r_data <= '0;
    end else if (flush) begin
      wp          <= '0;
      rp          <= '0;
      cnt         <= '0;
      overflow    <= 1'b0;
      user_r_data <= '0;
    end else begin
      if (wr_acc) wp <= wp + 1'b1;
      if (rd_acc) begin
        rp          <= rp + 1'b1;
        user_r_data <= mem[rp];
      end
      if (user_w_wren && user_w_full) overflow <= 1'b1;
      cnt <= cnt_nxt;
    end
  end

  // Session state register; flush forces IDLE.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n)  state <= S_IDLE;
    else if (flush)  state <= S_IDLE;
    else             state <= state_nxt;
  end

  // Session next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (user_w_open) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!user_w_open) state_nxt = (cnt_nxt == '0) ? S_EOF : S_DRAINING;
      end
      S_DRAINING: begin
        if (user_w_open)          state_nxt = S_ACTIVE;
        else if (cnt_nxt == '0)   state_nxt = S_EOF;
      end
      S_EOF: begin
        if (user_w_open) state_nxt = S_ACTIVE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from registers only.
  always_comb begin
    user_w_full  = (cnt == CNT_FULL);
    user_r_empty = (cnt == '0) || (state == S_EOF);
    user_r_eof   = (state == S_EOF);
    level        = cnt;
  end

endmodule
